sdram_arbiter: RTL and testbench

Three-port request arbiter that shares the single-transaction `sdram` controller among the CPU (port 0), the video fetcher (port 1) and the DMA/disk engine (port 2). It converts each requester's level `req`/`ack` handshake into the controller's edge-triggered `rd`/`we` strobes. It tracks the controller's `ready` flag, including the read-hit case where `ready` never drops, and returns read data per port. It sits between the requesters and `sdram`, in the `clk` domain.

---
 rtl/sdram_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Three-port req/ack arbiter in front of a single-transaction SDRAM controller.
// Port 0 has priority with a fairness cap; ports 1 and 2 share a round-robin pointer.
module sdram_arbiter #(
    parameter int MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [24:0] p0_addr,
    input  logic [15:0] p0_din,
    input  logic [1:0]  p0_wtbt,
    output logic        p0_ack,
    output logic [15:0] p0_dout,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [24:0] p1_addr,
    input  logic [15:0] p1_din,
    input  logic [1:0]  p1_wtbt,
    output logic        p1_ack,
    output logic [15:0] p1_dout,

    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [24:0] p2_addr,
    input  logic [15:0] p2_din,
    input  logic [1:0]  p2_wtbt,
    output logic        p2_ack,
    output logic [15:0] p2_dout,

    output logic [24:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_wtbt,
    output logic        sd_rd,
    output logic        sd_we,
    input  logic [15:0] sd_dout,
    input  logic        sd_ready,

    output logic [1:0]  grant
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_CHECK,
        ST_WAIT,
        ST_RECOVER
    } state_t;

    localparam logic [3:0] CONSEC_MAX = 4'(MAX_CONSEC);

    // Entry 3 is a dummy so the "no winner" index 3 stays in range.
    logic [3:0]        req_in;
    logic [3:0]        we_in;
    logic [3:0][24:0]  addr_in;
    logic [3:0][15:0]  din_in;
    logic [3:0][1:0]   wtbt_in;

    assign req_in  = {1'b0, p2_req, p1_req, p0_req};
    assign we_in   = {1'b0, p2_we, p1_we, p0_we};
    assign addr_in = {25'd0, p2_addr, p1_addr, p0_addr};
    assign din_in  = {16'd0, p2_din, p1_din, p0_din};
    assign wtbt_in = {2'd0, p2_wtbt, p1_wtbt, p0_wtbt};

    state_t           state_q, state_d;
    logic [24:0]      sd_addr_q, sd_addr_d;
    logic [15:0]      sd_din_q, sd_din_d;
    logic [1:0]       sd_wtbt_q, sd_wtbt_d;
    logic             sd_rd_q, sd_rd_d;
    logic             sd_we_q, sd_we_d;
    logic [1:0]       grant_q, grant_d;
    logic [3:0]       consec_q, consec_d;
    logic             rr_q, rr_d;
    logic [2:0]       ack_q, ack_d;
    logic [2:0][15:0] dout_q, dout_d;

    logic       other_pending;
    logic [1:0] winner;
    logic       complete;

    // rr_q = 0 means port 1 is preferred next, 1 means port 2.
    always_comb begin
        other_pending = req_in[1] | req_in[2];
        winner        = 2'd3;
        if (req_in[0] && !(consec_q == CONSEC_MAX && other_pending)) begin
            winner = 2'd0;
        end else if (other_pending) begin
            if (!rr_q) begin
                winner = req_in[1] ? 2'd1 : 2'd2;
            end else begin
                winner = req_in[2] ? 2'd2 : 2'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sd_addr_d = sd_addr_q;
        sd_din_d  = sd_din_q;
        sd_wtbt_d = sd_wtbt_q;
        sd_rd_d   = sd_rd_q;
        sd_we_d   = sd_we_q;
        grant_d   = grant_q;
        consec_d  = consec_q;
        rr_d      = rr_q;
        ack_d     = 3'b000;
        dout_d    = dout_q;
        complete  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!other_pending) begin
                    consec_d = 4'd0;
                end
                if (sd_ready && winner != 2'd3) begin
                    sd_addr_d = addr_in[winner];
                    sd_din_d  = din_in[winner];
                    sd_wtbt_d = wtbt_in[winner];
                    sd_we_d   = we_in[winner];
                    sd_rd_d   = ~we_in[winner];
                    grant_d   = winner;
                    state_d   = ST_STROBE;
                    if (winner == 2'd0) begin
                        if (other_pending && consec_q != CONSEC_MAX) begin
                            consec_d = consec_q + 4'd1;
                        end
                    end else begin
                        consec_d = 4'd0;
                        rr_d     = (winner == 2'd1);
                    end
                end
            end
            ST_STROBE: state_d = ST_CHECK;
            // A read hit leaves ready high, so CHECK may complete directly.
            ST_CHECK, ST_WAIT: begin
                if (sd_ready) begin
                    complete = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (complete) begin
            for (int i = 0; i < 3; i++) begin
                if (grant_q == 2'(i)) begin
                    ack_d[i] = 1'b1;
                    if (sd_rd_q) begin
                        dout_d[i] = sd_dout;
                    end
                end
            end
            sd_rd_d = 1'b0;
            sd_we_d = 1'b0;
            grant_d = 2'd3;
            state_d = ST_RECOVER;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sd_addr_q <= '0;
            sd_din_q  <= '0;
            sd_wtbt_q <= '0;
            sd_rd_q   <= 1'b0;
            sd_we_q   <= 1'b0;
            grant_q   <= 2'd3;
            consec_q  <= '0;
            rr_q      <= 1'b0;
            ack_q     <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            sd_addr_q <= sd_addr_d;
            sd_din_q  <= sd_din_d;
            sd_wtbt_q <= sd_wtbt_d;
            sd_rd_q   <= sd_rd_d;
            sd_we_q   <= sd_we_d;
            grant_q   <= grant_d;
            consec_q  <= consec_d;
            rr_q      <= rr_d;
            ack_q     <= ack_d;
            dout_q    <= dout_d;
        end
    end

    assign sd_addr = sd_addr_q;
    assign sd_din  = sd_din_q;
    assign sd_wtbt = sd_wtbt_q;
    assign sd_rd   = sd_rd_q;
    assign sd_we   = sd_we_q;
    assign grant   = grant_q;
    assign p0_ack  = ack_q[0];
    assign p1_ack  = ack_q[1];
    assign p2_ack  = ack_q[2];
    assign p0_dout = dout_q[0];
    assign p1_dout = dout_q[1];
    assign p2_dout = dout_q[2];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small behavioural SDRAM controller model.
// Controller model: 3-cycle miss latency, read hit on repeat of the last read word.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_we, p1_req, p1_we, p2_req, p2_we;
    logic [24:0] p0_addr, p1_addr, p2_addr;
    logic [15:0] p0_din, p1_din, p2_din;
    logic [1:0]  p0_wtbt, p1_wtbt, p2_wtbt;
    logic        p0_ack, p1_ack, p2_ack;
    logic [15:0] p0_dout, p1_dout, p2_dout;
    logic [24:0] sd_addr;
    logic [15:0] sd_din;
    logic [1:0]  sd_wtbt;
    logic        sd_rd, sd_we;
    logic [15:0] sd_dout;
    logic        sd_ready;
    logic [1:0]  grant;
    logic [2:0]  acks;

    int checks = 0;
    int errors = 0;
    int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};

    logic        model_clear;
    logic        ctrl_init;
    logic        model_ready;
    logic [15:0] model_dout;
    logic        prev_strobe;
    int          busy;
    logic        last_valid;
    logic [23:0] last_word;
    logic [23:0] pend_word;
    logic        wr_valid;
    logic [23:0] wr_word;
    logic [15:0] wr_data;

    always #5 clk = ~clk;

    assign sd_ready = model_ready & ~ctrl_init;
    assign sd_dout  = model_dout;
    assign acks     = {p2_ack, p1_ack, p0_ack};

    sdram_arbiter #(.MAX_CONSEC(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
        .p0_wtbt(p0_wtbt), .p0_ack(p0_ack), .p0_dout(p0_dout),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_wtbt(p1_wtbt), .p1_ack(p1_ack), .p1_dout(p1_dout),
        .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_din(p2_din),
        .p2_wtbt(p2_wtbt), .p2_ack(p2_ack), .p2_dout(p2_dout),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt),
        .sd_rd(sd_rd), .sd_we(sd_we), .sd_dout(sd_dout), .sd_ready(sd_ready),
        .grant(grant)
    );

    function automatic logic [15:0] read_word(input logic [23:0] w);
        if (wr_valid && wr_word == w) return wr_data;
        if (w == 24'h80) return 16'hA55A;
        return 16'h1000 + w[15:0];
    endfunction

    // Controller model reacts to strobe rising edges, like the real controller.
    always @(posedge clk) begin
        if (model_clear) begin
            prev_strobe <= 1'b0;
            busy        <= 0;
            model_ready <= 1'b1;
            model_dout  <= 16'h0;
            last_valid  <= 1'b0;
            last_word   <= '0;
            pend_word   <= '0;
            wr_valid    <= 1'b0;
            wr_word     <= '0;
            wr_data     <= '0;
        end else begin
            prev_strobe <= sd_rd | sd_we;
            if ((sd_rd | sd_we) && !prev_strobe) begin
                if (sd_we) begin
                    wr_valid    <= 1'b1;
                    wr_word     <= sd_addr[24:1];
                    wr_data     <= sd_din;
                    last_valid  <= 1'b0;
                    busy        <= 3;
                    model_ready <= 1'b0;
                end else if (last_valid && last_word == sd_addr[24:1]) begin
                    model_dout <= read_word(sd_addr[24:1]);
                end else begin
                    last_valid  <= 1'b1;
                    last_word   <= sd_addr[24:1];
                    pend_word   <= sd_addr[24:1];
                    busy        <= 3;
                    model_ready <= 1'b0;
                end
            end else if (busy > 0) begin
                busy <= busy - 1;
                if (busy == 1) begin
                    model_ready <= 1'b1;
                    model_dout  <= read_word(pend_word);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [24:0] addr, input logic [15:0] din,
                                 input logic [1:0] wtbt);
        case (port)
            0: begin p0_req = req; p0_we = we; p0_addr = addr; p0_din = din; p0_wtbt = wtbt; end
            1: begin p1_req = req; p1_we = we; p1_addr = addr; p1_din = din; p1_wtbt = wtbt; end
            default: begin p2_req = req; p2_we = we; p2_addr = addr; p2_din = din; p2_wtbt = wtbt; end
        endcase
    endtask

    task automatic waitAck(input int port, input int budget, output int cycles);
        cycles = 0;
        while (acks[port] !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
        checkOutput($sformatf("ack_p%0d_seen", port), 32'(acks[port]), 32'd1);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int strobe_seen;
        int low_cnt;
        int port_seen;

        reset_n     = 1'b0;
        model_clear = 1'b1;
        ctrl_init   = 1'b1;
        for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
        repeat (3) step();

        checkOutput("rst_grant", 32'(grant), 32'd3);
        checkOutput("rst_sd_rd", 32'(sd_rd), 32'd0);
        checkOutput("rst_sd_we", 32'(sd_we), 32'd0);
        checkOutput("rst_sd_addr", 32'(sd_addr), 32'd0);
        checkOutput("rst_acks", 32'(acks), 32'd0);
        checkOutput("rst_p0_dout", 32'(p0_dout), 32'd0);

        // Post-reset gating: controller not ready for 100 cycles.
        model_clear = 1'b0;
        reset_n     = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, 25'h000010, 16'h0, 2'b00);
        strobe_seen = 0;
        repeat (100) begin
            step();
            if (sd_rd || sd_we) strobe_seen = 1;
        end
        checkOutput("gate_no_strobe", 32'(strobe_seen), 32'd0);
        checkOutput("gate_grant_idle", 32'(grant), 32'd3);
        ctrl_init = 1'b0;
        step();
        checkOutput("gate_sd_rd", 32'(sd_rd), 32'd1);
        checkOutput("gate_grant", 32'(grant), 32'd1);
        waitAck(1, 20, cyc);
        checkOutput("gate_p1_dout", 32'(p1_dout), 32'h1008);
        applyStimulus(1, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
        step();

        // Miss read on port 0.
        applyStimulus(0, 1'b1, 1'b0, 25'h000100, 16'h0, 2'b00);
        waitAck(0, 20, cyc);
        checkOutput("miss_latency", 32'(cyc), 32'd6);
        checkOutput("miss_p0_dout", 32'(p0_dout), 32'hA55A);
        applyStimulus(0, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
        step();
        checkOutput("ack_one_cycle", 32'(p0_ack), 32'd0);
        checkOutput("idle_grant", 32'(grant), 32'd3);

        // Read hit on the same 16-bit word.
        applyStimulus(0, 1'b1, 1'b0, 25'h000101, 16'h0, 2'b00);
        waitAck(0, 20, cyc);
        checkOutput("hit_latency", 32'(cyc), 32'd3);
        checkOutput("hit_sd_addr", 32'(sd_addr), 32'h000101);
        checkOutput("hit_p0_dout", 32'(p0_dout), 32'hA55A);
        applyStimulus(0, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
        step();

        // Fresh reset so consec and the round-robin pointer start from known values.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;

        // Priority and fairness with all three ports requesting continuously.
        applyStimulus(0, 1'b1, 1'b0, 25'h000100, 16'h0, 2'b00);
        applyStimulus(1, 1'b1, 1'b0, 25'h000010, 16'h0, 2'b00);
        applyStimulus(2, 1'b1, 1'b0, 25'h000030, 16'h0, 2'b00);
        for (int k = 0; k < 10; k++) begin
            cyc = 0;
            while (acks == 3'b000 && cyc < 20) begin
                step();
                cyc++;
            end
            port_seen = p0_ack ? 0 : p1_ack ? 1 : p2_ack ? 2 : 3;
            checkOutput($sformatf("prio_grant%0d", k), 32'(port_seen), 32'(exp_seq[k]));
            if (k == 9) begin
                for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
            end
            step();
        end
        checkOutput("prio_p2_dout", 32'(p2_dout), 32'h1018);

        // Write then read of the same address, with strobe gap.
        applyStimulus(2, 1'b1, 1'b1, 25'h000040, 16'h1234, 2'b11);
        step();
        checkOutput("wr_sd_we", 32'(sd_we), 32'd1);
        checkOutput("wr_sd_rd", 32'(sd_rd), 32'd0);
        checkOutput("wr_sd_din", 32'(sd_din), 32'h1234);
        checkOutput("wr_sd_wtbt", 32'(sd_wtbt), 32'd3);
        checkOutput("wr_grant", 32'(grant), 32'd2);
        waitAck(2, 20, cyc);
        checkOutput("wr_keeps_dout", 32'(p2_dout), 32'h1018);
        applyStimulus(2, 1'b1, 1'b0, 25'h000040, 16'h0, 2'b00);
        low_cnt = 0;
        cyc = 0;
        while (sd_rd !== 1'b1 && cyc < 10) begin
            if (!sd_rd && !sd_we) low_cnt++;
            step();
            cyc++;
        end
        checkOutput("rd_after_wr", 32'(sd_rd), 32'd1);
        checkOutput("strobe_gap_ge2", 32'(low_cnt >= 2), 32'd1);
        waitAck(2, 20, cyc);
        checkOutput("rd_after_wr_dout", 32'(p2_dout), 32'h1234);
        applyStimulus(2, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
        step();

        // Reset during WAIT, then re-grant once the controller is ready.
        applyStimulus(1, 1'b1, 1'b0, 25'h000050, 16'h0, 2'b00);
        repeat (4) step();
        checkOutput("pre_rst_sd_rd", 32'(sd_rd), 32'd1);
        checkOutput("pre_rst_grant", 32'(grant), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_sd_rd", 32'(sd_rd), 32'd0);
        checkOutput("mid_rst_grant", 32'(grant), 32'd3);
        checkOutput("mid_rst_sd_addr", 32'(sd_addr), 32'd0);
        checkOutput("mid_rst_p1_dout", 32'(p1_dout), 32'd0);
        checkOutput("mid_rst_acks", 32'(acks), 32'd0);
        #1 reset_n = 1'b1;
        step();
        checkOutput("post_rst_gate_grant", 32'(grant), 32'd3);
        checkOutput("post_rst_gate_rd", 32'(sd_rd), 32'd0);
        step();
        checkOutput("regrant_sd_rd", 32'(sd_rd), 32'd1);
        checkOutput("regrant_grant", 32'(grant), 32'd1);
        waitAck(1, 20, cyc);
        checkOutput("regrant_p1_dout", 32'(p1_dout), 32'h1028);
        applyStimulus(1, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
